// File: rtl/pipe_hazard_ctrl.sv
// Pipeline controller: scoreboards in-flight destinations to drive load-use stalls,
// DEC->EXE operand forwarding, branch flush sequencing and memory-wait freezing.
module pipe_hazard_ctrl #(
    parameter int REG_AW    = 4,
    parameter int FLUSH_LEN = 1,
    parameter int R0_ZERO   = 1,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              dec_valid,
    input  logic [REG_AW-1:0] dec_rs1,
    input  logic [REG_AW-1:0] dec_rs2,
    input  logic              dec_use_rs1,
    input  logic              dec_use_rs2,
    input  logic [REG_AW-1:0] dec_rd,
    input  logic              dec_needs_wb,
    input  logic              dec_is_load,
    input  logic              exe_branch_taken,
    input  logic              mem_wait,
    output logic              pc_hold,
    output logic              dec_hold,
    output logic              exe_bubble,
    output logic              dec_flush,
    output logic              exe_flush,
    output logic              mem_flush,
    output logic              pipe_freeze,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [1:0] {RUN, FLUSH, FREEZE} state_t;

    localparam logic [1:0] FC_INIT = 2'(FLUSH_LEN);

    state_t state, ret_state, eff_state, next_state, next_ret;
    logic [1:0] fc, next_fc;

    // Scoreboard slots: _p0 = EXE, _p1 = MEM, _p2 = WB
    logic              vld_p0, vld_p1, vld_p2;
    logic [REG_AW-1:0] rd_p0, rd_p1, rd_p2;
    logic              ld_p0, ld_p1, ld_p2;

    logic ma_e, ma_m, ma_w, mb_e, mb_m, mb_w;
    logic run_act, flush_act, lu_hazard, stall, branch_go;
    logic [1:0] sel_a, sel_b;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic rs_match(input logic use_rs, input logic vld,
                                      input logic [REG_AW-1:0] rd,
                                      input logic [REG_AW-1:0] rs);
        return use_rs && vld && (rd == rs) && !((R0_ZERO != 0) && (rs == '0));
    endfunction

    function automatic logic [1:0] pick_sel(input logic me, input logic mm,
                                            input logic mw, input logic ld_exe);
        if (me)      return ld_exe ? 2'b00 : 2'b01;
        else if (mm) return 2'b10;
        else if (mw) return 2'b11;
        else         return 2'b00;
    endfunction

    // While frozen the FSM remembers where it came from; drive behaviour from that
    assign eff_state = (state == FREEZE) ? ret_state : state;

    assign ma_e = rs_match(dec_use_rs1, vld_p0, rd_p0, dec_rs1);
    assign ma_m = rs_match(dec_use_rs1, vld_p1, rd_p1, dec_rs1);
    assign ma_w = rs_match(dec_use_rs1, vld_p2, rd_p2, dec_rs1);
    assign mb_e = rs_match(dec_use_rs2, vld_p0, rd_p0, dec_rs2);
    assign mb_m = rs_match(dec_use_rs2, vld_p1, rd_p1, dec_rs2);
    assign mb_w = rs_match(dec_use_rs2, vld_p2, rd_p2, dec_rs2);

    assign sel_a     = pick_sel(ma_e, ma_m, ma_w, ld_p0);
    assign sel_b     = pick_sel(mb_e, mb_m, mb_w, ld_p0);
    assign lu_hazard = (ma_e || mb_e) && ld_p0;

    assign run_act   = nrst && !mem_wait && (eff_state == RUN);
    assign flush_act = nrst && !mem_wait && (eff_state == FLUSH);
    assign stall     = run_act && lu_hazard && !exe_branch_taken;
    assign branch_go = run_act && exe_branch_taken;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state     <= RUN;
            ret_state <= RUN;
            fc        <= 2'd0;
        end else begin
            state     <= next_state;
            ret_state <= next_ret;
            fc        <= next_fc;
        end
    end

    always_comb begin
        next_state = state;
        next_ret   = ret_state;
        next_fc    = fc;
        if (mem_wait) begin
            next_state = FREEZE;
            next_ret   = eff_state;
        end else begin
            case (eff_state)
                RUN: begin
                    next_state = exe_branch_taken ? FLUSH : RUN;
                    if (exe_branch_taken) next_fc = FC_INIT;
                end
                FLUSH: begin
                    if (fc <= 2'd1) next_state = RUN;
                    else begin
                        next_state = FLUSH;
                        next_fc    = fc - 2'd1;
                    end
                end
                default: next_state = RUN;
            endcase
        end
    end

    always_comb begin
        pipe_freeze = nrst && mem_wait;
        pc_hold     = pipe_freeze || stall;
        dec_hold    = pipe_freeze || stall;
        exe_bubble  = stall;
        dec_flush   = flush_act;
        exe_flush   = flush_act;
        mem_flush   = flush_act;
        fwd_a_sel   = run_act ? sel_a : 2'b00;
        fwd_b_sel   = run_act ? sel_b : 2'b00;
    end

    // Scoreboard advance: valid bits are control, slot payload is plain data
    always_ff @(posedge clk) begin
        if (!nrst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else if (!mem_wait) begin
            vld_p2 <= vld_p1;
            vld_p1 <= flush_act ? 1'b0 : vld_p0;
            vld_p0 <= flush_act ? 1'b0 : (dec_valid && dec_needs_wb && !stall);
        end
    end

    always_ff @(posedge clk) begin
        if (!mem_wait) begin
            rd_p2 <= rd_p1;
            ld_p2 <= ld_p1;
            rd_p1 <= rd_p0;
            ld_p1 <= ld_p0;
            rd_p0 <= dec_rd;
            ld_p0 <= dec_is_load;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall)     stall_cnt <= sat_inc(stall_cnt);
            if (branch_go) flush_cnt <= sat_inc(flush_cnt);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a slot-array reference model.
module tb_pipe_hazard_ctrl;

    localparam int REG_AW    = 4;
    localparam int FLUSH_LEN = 1;
    localparam int CNT_W     = 5;
    localparam int CMAX      = (1 << CNT_W) - 1;

    logic clk, nrst;
    logic dec_valid, dec_use_rs1, dec_use_rs2, dec_needs_wb, dec_is_load;
    logic [REG_AW-1:0] dec_rs1, dec_rs2, dec_rd;
    logic exe_branch_taken, mem_wait;
    logic pc_hold, dec_hold, exe_bubble, dec_flush, exe_flush, mem_flush, pipe_freeze;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int failures = 0;

    pipe_hazard_ctrl #(.REG_AW(REG_AW), .FLUSH_LEN(FLUSH_LEN), .R0_ZERO(1), .CNT_W(CNT_W)) dut (
        .clk(clk), .nrst(nrst), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .dec_rd(dec_rd),
        .dec_needs_wb(dec_needs_wb), .dec_is_load(dec_is_load),
        .exe_branch_taken(exe_branch_taken), .mem_wait(mem_wait),
        .pc_hold(pc_hold), .dec_hold(dec_hold), .exe_bubble(exe_bubble),
        .dec_flush(dec_flush), .exe_flush(exe_flush), .mem_flush(mem_flush),
        .pipe_freeze(pipe_freeze), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: slot 0 = EXE, 1 = MEM, 2 = WB
    bit m_v[3];
    int m_rd[3];
    bit m_ld[3];
    int flush_left = 0;
    int m_sc = 0, m_fc = 0;
    bit started = 0;

    function automatic int model_sel(input int rs, input bit use_rs);
        for (int i = 0; i < 3; i++)
            if (use_rs && m_v[i] && m_rd[i] == rs && rs != 0)
                return (i == 0 && m_ld[0]) ? 0 : i + 1;
        return 0;
    endfunction

    function automatic bit model_lu();
        bit a, b;
        a = dec_use_rs1 && m_v[0] && m_ld[0] && m_rd[0] == int'(dec_rs1) && dec_rs1 != 0;
        b = dec_use_rs2 && m_v[0] && m_ld[0] && m_rd[0] == int'(dec_rs2) && dec_rs2 != 0;
        return a || b;
    endfunction

    always @(posedge clk) begin
        if (!nrst) begin
            for (int i = 0; i < 3; i++) m_v[i] = 0;
            flush_left = 0;
            m_sc = 0;
            m_fc = 0;
            started = 1;
        end else if (started && !mem_wait) begin
            if (flush_left > 0) begin
                m_v[2] = m_v[1]; m_rd[2] = m_rd[1]; m_ld[2] = m_ld[1];
                m_v[1] = 0;
                m_v[0] = 0;
                flush_left--;
            end else begin
                bit st;
                st = model_lu() && !exe_branch_taken;
                if (st && m_sc < CMAX) m_sc++;
                for (int i = 2; i > 0; i--) begin
                    m_v[i] = m_v[i-1]; m_rd[i] = m_rd[i-1]; m_ld[i] = m_ld[i-1];
                end
                m_v[0]  = dec_valid && dec_needs_wb && !st;
                m_rd[0] = int'(dec_rd);
                m_ld[0] = dec_is_load;
                if (exe_branch_taken) begin
                    flush_left = FLUSH_LEN;
                    if (m_fc < CMAX) m_fc++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            bit on, frz, fl, st;
            int ea, eb;
            on  = nrst;
            frz = on && mem_wait;
            fl  = on && !frz && flush_left > 0;
            st  = on && !frz && !fl && model_lu() && !exe_branch_taken;
            ea  = (on && !frz && !fl) ? model_sel(int'(dec_rs1), dec_use_rs1) : 0;
            eb  = (on && !frz && !fl) ? model_sel(int'(dec_rs2), dec_use_rs2) : 0;
            check("m_pipe_freeze", pipe_freeze, frz);
            check("m_pc_hold", pc_hold, frz || st);
            check("m_dec_hold", dec_hold, frz || st);
            check("m_exe_bubble", exe_bubble, st);
            check("m_dec_flush", dec_flush, fl);
            check("m_exe_flush", exe_flush, fl);
            check("m_mem_flush", mem_flush, fl);
            check("m_fwd_a", fwd_a_sel, ea);
            check("m_fwd_b", fwd_b_sel, eb);
            check("m_stall_cnt", stall_cnt, m_sc);
            check("m_flush_cnt", flush_cnt, m_fc);
        end
    end

    task automatic idle();
        dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_use_rs1 = 0; dec_use_rs2 = 0;
        dec_rd = 0; dec_needs_wb = 0; dec_is_load = 0;
        exe_branch_taken = 0; mem_wait = 0;
    endtask

    task automatic instr(input int rs1, input bit u1, input int rs2, input bit u2,
                         input int rd, input bit wb, input bit ld);
        dec_valid = 1;
        dec_rs1 = 4'(rs1); dec_use_rs1 = u1;
        dec_rs2 = 4'(rs2); dec_use_rs2 = u2;
        dec_rd = 4'(rd); dec_needs_wb = wb; dec_is_load = ld;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        idle();
        nrst = 0;
        repeat (2) @(posedge clk);
        #1 nrst = 1;

        // Forwarding from EXE, MEM, WB
        instr(0, 0, 0, 0, 3, 1, 0);
        smp();
        check("rst_pc_hold", pc_hold, 0);
        check("rst_flush", dec_flush, 0);
        check("rst_fwd_a", fwd_a_sel, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_flush_cnt", flush_cnt, 0);
        nxt();
        instr(3, 1, 0, 0, 6, 1, 0);
        smp(); check("fwd_exe", fwd_a_sel, 1);
        nxt();
        instr(0, 0, 3, 1, 7, 1, 0);
        smp(); check("fwd_mem", fwd_b_sel, 2);
        nxt();
        instr(3, 1, 0, 0, 0, 0, 0);
        smp(); check("fwd_wb", fwd_a_sel, 3);
        nxt();

        // Load-use
        instr(0, 0, 0, 0, 5, 1, 1);
        nxt();
        instr(0, 0, 5, 1, 8, 1, 0);
        smp();
        check("lu_bubble", exe_bubble, 1);
        check("lu_pc_hold", pc_hold, 1);
        check("lu_dec_hold", dec_hold, 1);
        check("lu_fwd_b", fwd_b_sel, 0);
        nxt();
        smp();
        check("lu_after_fwd_b", fwd_b_sel, 2);
        check("lu_after_bubble", exe_bubble, 0);
        check("lu_stall_cnt", stall_cnt, 1);
        nxt();

        // Taken branch
        instr(0, 0, 0, 0, 9, 1, 0);
        exe_branch_taken = 1;
        smp(); check("br_no_flush_yet", dec_flush, 0);
        nxt();
        idle();
        smp();
        check("br_dec_flush", dec_flush, 1);
        check("br_exe_flush", exe_flush, 1);
        check("br_mem_flush", mem_flush, 1);
        check("br_flush_cnt", flush_cnt, 1);
        nxt();
        instr(9, 1, 0, 0, 0, 0, 0);
        smp();
        check("br_after_fwd_a", fwd_a_sel, 0);
        check("br_after_flush", dec_flush, 0);
        nxt();

        // Memory wait during a load-use hazard
        instr(0, 0, 0, 0, 4, 1, 1);
        nxt();
        instr(4, 1, 0, 0, 10, 1, 0);
        mem_wait = 1;
        for (int i = 0; i < 3; i++) begin
            smp();
            check("frz_freeze", pipe_freeze, 1);
            check("frz_bubble", exe_bubble, 0);
            nxt();
        end
        mem_wait = 0;
        smp();
        check("frz_stall", exe_bubble, 1);
        check("frz_stall_cnt_before", stall_cnt, 1);
        nxt();
        smp();
        check("frz_after_bubble", exe_bubble, 0);
        check("frz_after_fwd_a", fwd_a_sel, 2);
        check("frz_stall_cnt", stall_cnt, 2);
        nxt();

        // r0 never hazards, even from a load
        instr(0, 0, 0, 0, 0, 1, 1);
        nxt();
        instr(0, 1, 0, 0, 1, 1, 0);
        smp();
        check("r0_fwd_a", fwd_a_sel, 0);
        check("r0_bubble", exe_bubble, 0);
        nxt();

        // Reset in the middle of a flush
        idle();
        exe_branch_taken = 1;
        nxt();
        exe_branch_taken = 0;
        nrst = 0;
        nxt();
        nrst = 1;
        smp();
        check("rstf_dec_flush", dec_flush, 0);
        check("rstf_exe_flush", exe_flush, 0);
        check("rstf_pc_hold", pc_hold, 0);
        check("rstf_stall_cnt", stall_cnt, 0);
        check("rstf_flush_cnt", flush_cnt, 0);
        nxt();

        // Saturate the stall counter
        for (int i = 0; i < CMAX + 9; i++) begin
            instr(0, 0, 0, 0, 5, 1, 1);
            nxt();
            instr(0, 0, 5, 1, 8, 1, 0);
            nxt();
            nxt();
        end
        smp();
        check("sat_stall_cnt", stall_cnt, CMAX);
        nxt();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            dec_valid        = ($urandom_range(0, 3) != 0);
            dec_rs1          = 4'($urandom_range(0, 3));
            dec_rs2          = 4'($urandom_range(0, 3));
            dec_use_rs1      = 1'($urandom_range(0, 1));
            dec_use_rs2      = 1'($urandom_range(0, 1));
            dec_rd           = 4'($urandom_range(0, 3));
            dec_needs_wb     = ($urandom_range(0, 3) != 0);
            dec_is_load      = ($urandom_range(0, 2) == 0);
            exe_branch_taken = ($urandom_range(0, 9) == 0);
            mem_wait         = ($urandom_range(0, 7) == 0);
            nrst             = ($urandom_range(0, 99) != 0);
            nxt();
        end

        idle();
        nrst = 1;
        nxt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
